// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 encodings and master FSM state type.
// Used by the master port and by the slave models.
package ysyx_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  typedef enum logic [2:0] {
    MST_IDLE  = 3'd0,
    MST_RADDR = 3'd1,
    MST_RDATA = 3'd2,
    MST_WREQ  = 3'd3,
    MST_WRESP = 3'd4
  } mst_state_e;

  // EXOKAY is an error here too: this master never issues exclusive accesses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_master_port_if.sv
// AXI4 five-channel bus (single-beat subset) seen from master and slave sides.
interface axi4_lite_master_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic                rlast;
  logic [ID_W-1:0]     rid;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                wlast;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     bid;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst,
    input  arready,
    input  rdata, rresp, rvalid, rlast, rid,
    output rready,
    output awaddr, awvalid, awid, awlen, awsize, awburst,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bresp, bvalid, bid,
    output bready
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst,
    output arready,
    output rdata, rresp, rvalid, rlast, rid,
    input  rready,
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bresp, bvalid, bid,
    input  bready
  );

endinterface

// File: rtl/axi4_lite_master_port.sv
// Single-outstanding AXI4 master: turns one CPU load/store request into one
// single-beat AXI read or write and returns data plus error status.
module axi4_lite_master_port
  import ysyx_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  axi4_lite_master_port_if.master axi
);

  function automatic logic rd_err(input logic [1:0] resp, input logic [3:0] id,
                                  input logic last);
    return resp_is_err(resp) || (id != AXI_ID) || !last;
  endfunction

  function automatic logic wr_err(input logic [1:0] resp, input logic [3:0] id);
    return resp_is_err(resp) || (id != AXI_ID);
  endfunction

  mst_state_e state_q, state_d;

  logic [ADDR_W-1:0]   addr_p0;
  logic [2:0]          size_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [DATA_W/8-1:0] wstrb_p0;

  logic aw_done_q, w_done_q;
  logic req_fire;
  logic r_hs, b_hs;
  logic aw_fin, w_fin;

  assign req_ready = (state_q == MST_IDLE) && !resp_valid;
  assign req_fire  = req_valid && req_ready;

  // Handshakes are decoded from state, never from our own valids, so no AXI
  // input reaches a valid or req_ready combinationally.
  assign r_hs   = (state_q == MST_RDATA) && axi.rvalid;
  assign b_hs   = (state_q == MST_WRESP) && axi.bvalid;
  assign aw_fin = aw_done_q || axi.awready;
  assign w_fin  = w_done_q  || axi.wready;

  assign axi.araddr  = addr_p0;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = size_p0;
  assign axi.arburst = AXI_BURST_INCR;

  assign axi.awaddr  = addr_p0;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = size_p0;
  assign axi.awburst = AXI_BURST_INCR;

  assign axi.wdata   = wdata_p0;
  assign axi.wstrb   = wstrb_p0;
  assign axi.wlast   = axi.wvalid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    unique case (state_q)
      MST_IDLE: begin
        if (req_fire) state_d = req_wen ? MST_WREQ : MST_RADDR;
      end
      MST_RADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = MST_RDATA;
      end
      MST_RDATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_d = MST_IDLE;
      end
      MST_WREQ: begin
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        if (aw_fin && w_fin) state_d = MST_WRESP;
      end
      MST_WRESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = MST_IDLE;
      end
      default: state_d = MST_IDLE;
    endcase
  end

  // Request latch: captured on acceptance, held for the whole transaction.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr_p0  <= req_addr;
      size_p0  <= req_size;
      wdata_p0 <= req_wdata;
      wstrb_p0 <= req_wstrb;
    end
  end

  // Response register and per-channel write completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= r_hs || b_hs;
      if (r_hs) begin
        resp_rdata <= axi.rdata;
        resp_err   <= rd_err(axi.rresp, axi.rid, axi.rlast);
      end
      if (b_hs) resp_err <= wr_err(axi.bresp, axi.bid);
      if (state_q == MST_WREQ) begin
        if (aw_fin && w_fin) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_fin;
          w_done_q  <= w_fin;
        end
      end
    end
  end

endmodule

// File: doc/axi4_lite_master_port.md
Name: axi4_lite_master_port

Overview:
- Single-outstanding AXI4 master that converts a simple CPU-side load/store request into one single-beat AXI4 read or write transaction.
- Sits between the core's LSU/IFU arbiter and the AXI4 interconnect, whose slaves are the SRAM/UART model and peripherals.
- Generates AR/R or AW/W/B traffic, then returns read data and error status to the requester.

Parameters:
- AXI_ID, 4'd0, constant value driven on arid/awid and expected on rid/bid.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed 32 in this design; wstrb width = DATA_W/8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle
- req_wen  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_size  in  3  AXI size code (0=byte, 1=half, 2=word)
- req_wdata  in  32  store data, already lane-aligned
- req_wstrb  in  4  byte enables
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data (undefined for writes)
- resp_err  out  1  rresp/bresp != OKAY, or ID/rlast mismatch
- AXI AR: araddr out 32, arvalid out 1, arready in 1, arid out 4, arlen out 8, arsize out 3, arburst out 2
- AXI R: rdata in 32, rresp in 2, rvalid in 1, rready out 1, rlast in 1, rid in 4
- AXI AW: awaddr out 32, awvalid out 1, awready in 1, awid out 4, awlen out 8, awsize out 3, awburst out 2
- AXI W: wdata out 32, wstrb out 4, wvalid out 1, wready in 1, wlast out 1
- AXI B: bresp in 2, bvalid in 1, bready out 1, bid in 4

Behaviour:
- Constants: arlen=awlen=0, arburst=awburst=2'b01 (INCR), wlast=wvalid.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/size/wdata/wstrb; go to RADDR (read) or WREQ (write).
  - A request is accepted on the same cycle it is presented.
- RADDR:
  - arvalid=1, araddr/arsize from the latched request.
  - Stay until arready, then go to RDATA.
  - arvalid must not drop and araddr must not change before the handshake.
- RDATA:
  - rready=1.
  - On rvalid, capture rdata into resp_rdata; resp_err = (rresp!=0) | (rid!=AXI_ID) | !rlast.
  - Pulse resp_valid for exactly one cycle (the cycle after the handshake), then go to IDLE.
- WREQ:
  - awvalid and wvalid asserted together.
  - Each handshake is tracked independently (aw_done, w_done flags); a channel's valid drops the cycle after its own handshake.
  - Simultaneous awready and wready completes both in one cycle.
  - Go to WRESP once both are done. The slave may accept AW and W in either order or together.
- WRESP:
  - bready=1.
  - On bvalid: resp_err = (bresp!=0) | (bid!=AXI_ID); pulse resp_valid one cycle; go to IDLE.
- req_ready:
  - Asserted only in IDLE and not during the resp_valid pulse cycle.
  - Minimum spacing: read = 3 cycles when the slave is zero-wait (AR, R, resp); write = 3 cycles.
- Latency:
  - resp_valid rises 1 cycle after the R or B handshake.
  - No combinational path from any AXI input to req_ready or to any AXI valid.
- Reset values: all valids/readies 0, resp_valid 0, resp_err 0, resp_rdata 0, state IDLE, done flags 0.
- Reset mid-operation returns to IDLE and abandons the transaction. The bench must also reset the slave.
- Requests presented while busy are ignored until req_ready is high. The requester must hold req_valid and its fields stable until accepted.
- Address is passed through unmodified; no alignment check, since the slave aligns it.

Decomposition:
- Shared package ysyx_axi_pkg:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - AXI_BURST_INCR
  - AXI_SIZE_1B/2B/4B
  - master FSM state encoding (3-bit)
- This package is reused by the slave models.
- No sub-module; a single flat FSM with the request latch is natural.

Test Plan:
- Read, zero-wait slave: req addr=0x80000010, size=2, slave rdata=0x12345678 → arvalid for 1 cycle, rready handshake, resp_valid pulse with rdata=0x12345678, err=0; req_ready back 1 cycle later.
- Write, AW before W: slave raises awready at cycle 1 and wready at cycle 3, data=0xDEADBEEF, wstrb=4'b0011 → awvalid drops after cycle 1, wvalid held to cycle 3, wlast=1 with wvalid, one B → resp_valid, err=0.
- Write, W before AW, then both together on a second request → both orders and the simultaneous handshake reach WRESP exactly once, with no duplicate beats.
- Error paths: rresp=2'b10 on read → resp_err=1; bid=4'h3 with AXI_ID=0 → resp_err=1; rlast=0 → resp_err=1.
- Back-pressure: arready held low for 5 cycles with req_valid toggling → araddr/arvalid stable, req_ready=0 throughout, no second AR issued.
- Reset in RDATA (arready done, rvalid not yet) → next cycle all valids 0, req_ready=1, no resp_valid; a subsequent read completes normally.
